decode_execute_stage: RTL and testbench



---
 rtl/decode_execute_stage.sv | 133 +++++++++++++
 tb/tb_decode_execute_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_stage.sv
// -----------------------------------------------------------------------------
// decode_execute_stage
//
// Pipeline register between the decode (D) and execute (E) stages of the
// RISC-V core. On each rising edge of clk it captures the decoded instruction
// bundle and presents it to the execute stage on registered outputs. A valid
// instruction that is being stalled is frozen in place. An invalid bubble is
// always overwritten, even while stall is high.
//
// Optional feature macro: DE_STAGE_FLUSH_EN
//   Defined   -> a `flush` input exists. flush=1 at a rising edge clears the
//                whole stage to zero, including valid_out. Flush takes priority
//                over stall. Reset still takes priority over flush.
//   Undefined -> there is no flush port.
//
// Parameters
//   WORD_SIZE        width of pc, s1, s2 and immediate (default `WORD_SIZE, 32)
//
// Ports
//   clk                   in   1          rising-edge clock
//   rst_n                 in   1          asynchronous active-low reset
//   instruction_type      in   2          decoded instruction class
//   pc                    in   WORD_SIZE  instruction PC
//   opcode                in   7          RISC-V opcode
//   funct7                in   7          funct7 field
//   funct3                in   3          funct3 field
//   s1                    in   WORD_SIZE  source operand 1 value
//   s2                    in   WORD_SIZE  source operand 2 value
//   immediate             in   WORD_SIZE  sign-extended immediate
//   stall                 in   1          hazard/stall request from downstream
//   valid                 in   1          the instruction in this stage is valid
//   flush                 in   1          squash request (DE_STAGE_FLUSH_EN only)
//   instruction_type_out .. immediate_out   registered copies of the inputs
//   valid_out             out  1          registered valid
// -----------------------------------------------------------------------------

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module decode_execute_stage #(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           instruction_type,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [6:0]           opcode,
  input  logic [6:0]           funct7,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] s1,
  input  logic [WORD_SIZE-1:0] s2,
  input  logic [WORD_SIZE-1:0] immediate,
  input  logic                 stall,
  input  logic                 valid,
`ifdef DE_STAGE_FLUSH_EN
  input  logic                 flush,
`endif
  output logic [1:0]           instruction_type_out,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic [6:0]           opcode_out,
  output logic [6:0]           funct7_out,
  output logic [2:0]           funct3_out,
  output logic [WORD_SIZE-1:0] s1_out,
  output logic [WORD_SIZE-1:0] s2_out,
  output logic [WORD_SIZE-1:0] immediate_out,
  output logic                 valid_out
);

  // Only a valid instruction can be frozen; bubbles are always replaced.
  logic wenable;
  assign wenable = ~(stall & valid);

  logic [1:0]           instruction_type_reg;
  logic [WORD_SIZE-1:0] pc_reg;
  logic [6:0]           opcode_reg;
  logic [6:0]           funct7_reg;
  logic [2:0]           funct3_reg;
  logic [WORD_SIZE-1:0] s1_reg;
  logic [WORD_SIZE-1:0] s2_reg;
  logic [WORD_SIZE-1:0] immediate_reg;
  logic                 valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction_type_reg <= '0;
      pc_reg               <= '0;
      opcode_reg           <= '0;
      funct7_reg           <= '0;
      funct3_reg           <= '0;
      s1_reg               <= '0;
      s2_reg               <= '0;
      immediate_reg        <= '0;
      valid_reg            <= 1'b0;
    end
`ifdef DE_STAGE_FLUSH_EN
    // Squash overrides a stall: the stage is emptied even if frozen.
    else if (flush) begin
      instruction_type_reg <= '0;
      pc_reg               <= '0;
      opcode_reg           <= '0;
      funct7_reg           <= '0;
      funct3_reg           <= '0;
      s1_reg               <= '0;
      s2_reg               <= '0;
      immediate_reg        <= '0;
      valid_reg            <= 1'b0;
    end
`endif
    else if (wenable) begin
      instruction_type_reg <= instruction_type;
      pc_reg               <= pc;
      opcode_reg           <= opcode;
      funct7_reg           <= funct7;
      funct3_reg           <= funct3;
      s1_reg               <= s1;
      s2_reg               <= s2;
      immediate_reg        <= immediate;
      valid_reg            <= valid;
    end
  end

  assign instruction_type_out = instruction_type_reg;
  assign pc_out               = pc_reg;
  assign opcode_out           = opcode_reg;
  assign funct7_out           = funct7_reg;
  assign funct3_out           = funct3_reg;
  assign s1_out               = s1_reg;
  assign s2_out               = s2_reg;
  assign immediate_out        = immediate_reg;
  assign valid_out            = valid_reg;

endmodule

// File: tb/tb_decode_execute_stage.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for decode_execute_stage (WORD_SIZE = 32).
// Expected values are hand-written constants for each step.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_decode_execute_stage;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [1:0]   instruction_type;
  logic [W-1:0] pc;
  logic [6:0]   opcode;
  logic [6:0]   funct7;
  logic [2:0]   funct3;
  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] immediate;
  logic         stall;
  logic         valid;
`ifdef DE_STAGE_FLUSH_EN
  logic         flush;
`endif
  logic [1:0]   instruction_type_out;
  logic [W-1:0] pc_out;
  logic [6:0]   opcode_out;
  logic [6:0]   funct7_out;
  logic [2:0]   funct3_out;
  logic [W-1:0] s1_out;
  logic [W-1:0] s2_out;
  logic [W-1:0] immediate_out;
  logic         valid_out;

  int pass_count = 0;
  int total_count = 0;

  decode_execute_stage #(.WORD_SIZE(W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .instruction_type     (instruction_type),
    .pc                   (pc),
    .opcode               (opcode),
    .funct7               (funct7),
    .funct3               (funct3),
    .s1                   (s1),
    .s2                   (s2),
    .immediate            (immediate),
    .stall                (stall),
    .valid                (valid),
`ifdef DE_STAGE_FLUSH_EN
    .flush                (flush),
`endif
    .instruction_type_out (instruction_type_out),
    .pc_out               (pc_out),
    .opcode_out           (opcode_out),
    .funct7_out           (funct7_out),
    .funct3_out           (funct3_out),
    .s1_out               (s1_out),
    .s2_out               (s2_out),
    .immediate_out        (immediate_out),
    .valid_out            (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic check_outs(input string step,
                            input logic [1:0] e_type, input logic [W-1:0] e_pc,
                            input logic [6:0] e_op, input logic [6:0] e_f7,
                            input logic [2:0] e_f3, input logic [W-1:0] e_s1,
                            input logic [W-1:0] e_s2, input logic [W-1:0] e_imm,
                            input logic e_valid);
    check({step, ".type"},  64'(instruction_type_out), 64'(e_type));
    check({step, ".pc"},    64'(pc_out),               64'(e_pc));
    check({step, ".op"},    64'(opcode_out),           64'(e_op));
    check({step, ".f7"},    64'(funct7_out),           64'(e_f7));
    check({step, ".f3"},    64'(funct3_out),           64'(e_f3));
    check({step, ".s1"},    64'(s1_out),               64'(e_s1));
    check({step, ".s2"},    64'(s2_out),               64'(e_s2));
    check({step, ".imm"},   64'(immediate_out),        64'(e_imm));
    check({step, ".valid"}, 64'(valid_out),            64'(e_valid));
    $display("step %s: type=%0d pc=%0h op=%b f7=%b f3=%b s1=%0d s2=%0d imm=%0d valid_out=%0b",
             step, instruction_type_out, pc_out, opcode_out, funct7_out, funct3_out,
             s1_out, s2_out, immediate_out, valid_out);
  endtask

  // Vector A: R-type add, vector B: I-type
  task automatic drive_a();
    instruction_type = 2'd0; pc = 32'h100; opcode = 7'b0110011; funct7 = 7'b0000000;
    funct3 = 3'b000; s1 = 32'd23; s2 = 32'd7; immediate = 32'd89;
  endtask

  task automatic drive_b();
    instruction_type = 2'd1; pc = 32'h104; opcode = 7'b0010011; funct7 = 7'b0000001;
    funct3 = 3'b111; s1 = 32'd212; s2 = 32'd73; immediate = 32'd879;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    valid = 1'b0;
`ifdef DE_STAGE_FLUSH_EN
    flush = 1'b0;
`endif
    drive_a();
    valid = 1'b1;

    // Reset held across an edge with loadable inputs: stage stays empty.
    edge_sample();
    check_outs("reset", 2'd0, 32'd0, 7'd0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Release between edges; first edge with rst_n=1 captures.
    #3 rst_n = 1'b1;
    drive_a(); stall = 1'b0; valid = 1'b1;
    #1 check("wen_s0v1", 64'(dut.wenable), 64'd1);
    edge_sample();
    check_outs("load_a", 2'd0, 32'h100, 7'b0110011, 7'b0000000, 3'b000, 32'd23, 32'd7, 32'd89, 1'b1);

    // Stall a valid instruction: hold A.
    drive_b(); stall = 1'b1; valid = 1'b1;
    #1 check("wen_s1v1", 64'(dut.wenable), 64'd0);
    edge_sample();
    check_outs("stall_hold", 2'd0, 32'h100, 7'b0110011, 7'b0000000, 3'b000, 32'd23, 32'd7, 32'd89, 1'b1);

    // Bubble, no stall: load B with valid_out=0.
    stall = 1'b0; valid = 1'b0;
    #1 check("wen_s0v0", 64'(dut.wenable), 64'd1);
    edge_sample();
    check_outs("bubble_b", 2'd1, 32'h104, 7'b0010011, 7'b0000001, 3'b111, 32'd212, 32'd73, 32'd879, 1'b0);

    // Bubble under stall is still overwritten (inputs changed to A to show it).
    drive_a(); stall = 1'b1; valid = 1'b0;
    #1 check("wen_s1v0", 64'(dut.wenable), 64'd1);
    edge_sample();
    check_outs("stall_bubble", 2'd0, 32'h100, 7'b0110011, 7'b0000000, 3'b000, 32'd23, 32'd7, 32'd89, 1'b0);

    // Load B valid, then stall it while inputs switch to A.
    drive_b(); stall = 1'b0; valid = 1'b1;
    edge_sample();
    check_outs("load_b", 2'd1, 32'h104, 7'b0010011, 7'b0000001, 3'b111, 32'd212, 32'd73, 32'd879, 1'b1);
    drive_a(); stall = 1'b1; valid = 1'b1;
    edge_sample();
    check_outs("stall_b", 2'd1, 32'h104, 7'b0010011, 7'b0000001, 3'b111, 32'd212, 32'd73, 32'd879, 1'b1);

    // Asynchronous reset mid-stall, between edges: clears immediately.
    #3 rst_n = 1'b0;
    #1 check_outs("async_rst", 2'd0, 32'd0, 7'd0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    stall = 1'b0;
    edge_sample();
    check_outs("rst_held", 2'd0, 32'd0, 7'd0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);

    // Release with a stalled valid instruction: normal rules, stage holds zeros.
    #3 rst_n = 1'b1;
    stall = 1'b1; valid = 1'b1;
    edge_sample();
    check_outs("post_rst_stall", 2'd0, 32'd0, 7'd0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    stall = 1'b0;
    edge_sample();
    check_outs("post_rst_load", 2'd0, 32'h100, 7'b0110011, 7'b0000000, 3'b000, 32'd23, 32'd7, 32'd89, 1'b1);

`ifdef DE_STAGE_FLUSH_EN
    // Flush beats stall on a valid instruction.
    drive_b(); stall = 1'b1; valid = 1'b1; flush = 1'b1;
    edge_sample();
    check_outs("flush_stall", 2'd0, 32'd0, 7'd0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    flush = 1'b0; stall = 1'b0;
    edge_sample();
    check_outs("after_flush", 2'd1, 32'h104, 7'b0010011, 7'b0000001, 3'b111, 32'd212, 32'd73, 32'd879, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
